// File: rtl/stream_sorter.sv
// stream_sorter: serial 8-element insertion sorter, fill a frame then drain it in ascending order
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   input handshake, i_in_data element to insert (FILL only)
//   o_out_valid/i_out_ready output handshake, o_out_data current sorted element (DRAIN only)
//   o_out_last              o_out_data is the frame maximum
//   o_fill_cnt              elements currently held
module stream_sorter #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [DATA_W-1:0]        i_in_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [DATA_W-1:0]        o_out_data,
   output logic                     o_out_last,
   output logic [$clog2(DEPTH):0]   o_fill_cnt
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   typedef enum logic {FILL, DRAIN} state_t;
   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_buf [DEPTH];
   logic [DATA_W-1:0] w_ins [DEPTH];
   logic [CW-1:0]     r_cnt, w_pos;
   logic [IW-1:0]     r_rd_idx;
   logic              w_acc, w_take;
   assign w_acc  = i_in_valid && r_state == FILL;
   assign w_take = i_out_ready && r_state == DRAIN;
   // The held entries are sorted, so the count of entries <= new value is the
   // insertion point; counting <= (not <) places a new element after its equals.
   always_comb begin
      w_pos = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) < r_cnt && r_buf[i] <= i_in_data) w_pos = w_pos + CW'(1);
      w_ins[0] = (w_pos == '0) ? i_in_data : r_buf[0];
      for (int i = 1; i < DEPTH; i++)
         w_ins[i] = (CW'(i) < w_pos) ? r_buf[i] : (CW'(i) == w_pos) ? i_in_data : r_buf[i-1];
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= FILL;
      else          r_state <= w_next;
   always_comb begin
      w_next      = r_state;
      o_in_ready  = r_state == FILL;
      o_out_valid = r_state == DRAIN;
      o_out_last  = r_state == DRAIN && r_rd_idx == IW'(DEPTH-1);
      o_out_data  = r_buf[r_rd_idx];
      o_fill_cnt  = r_cnt;
      if (w_acc && r_cnt == CW'(DEPTH-1)) w_next = DRAIN;
      if (w_take && r_rd_idx == IW'(DEPTH-1)) w_next = FILL;
   end
   // Read index wraps to 0 naturally after the last element since DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
         r_cnt    <= '0;
         r_rd_idx <= '0;
      end else if (w_acc) begin
         r_buf <= w_ins;
         r_cnt <= r_cnt + CW'(1);
      end else if (w_take) begin
         r_cnt    <= r_cnt - CW'(1);
         r_rd_idx <= r_rd_idx + IW'(1);
      end
endmodule

// File: tb/tb_stream_sorter.sv
// tb_stream_sorter: randomized self-checking bench for stream_sorter against a sorted-queue model
module tb_stream_sorter;
   localparam int N = 8;
   logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [7:0] in_data = 0;
   logic       in_ready, out_valid, out_last;
   logic [7:0] out_data;
   logic [3:0] fill_cnt;
   int         errors = 0, checks = 0;
   always #5 clk = ~clk;
   stream_sorter #(.DATA_W(8), .DEPTH(N)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_last(out_last), .o_fill_cnt(fill_cnt)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // gap: 0 back-to-back, 1 valid pattern 1,0,0 repeating, 2 random
   // stall: 0 none, 1 three-cycle stalls at output index 0 and N-1, 2 random
   task automatic run_frame(input logic [8*N-1:0] d, input int gap, input int stall);
      logic [7:0] q[$];
      int k = 0, c = 0, s;
      while (k < N) begin
         @(negedge clk);
         check("fill_in_ready", 32'(in_ready), 1);
         check("fill_out_valid", 32'(out_valid), 0);
         check("fill_cnt", 32'(fill_cnt), k);
         in_valid = gap == 0 || (gap == 1 && c % 3 == 0) || (gap == 2 && $urandom % 2 == 1) || c > 200;
         in_data  = in_valid ? d[8*k+:8] : 8'($urandom);
         c++;
         if (in_valid) begin
            q.push_back(in_data);
            k++;
         end
      end
      q.sort();
      for (int i = 0; i < N; i++) begin
         s = 0;
         do begin
            @(negedge clk);
            check("drain_valid", 32'(out_valid), 1);
            check("drain_data", 32'(out_data), 32'(q[i]));
            check("drain_last", 32'(out_last), 32'(i == N - 1));
            check("drain_in_ready", 32'(in_ready), 0);
            check("drain_cnt", 32'(fill_cnt), N - i);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = (stall == 1 && (i == 0 || i == N - 1)) ? s >= 3 :
                        (stall == 2) ? ($urandom % 4 != 0 || s > 50) : 1'b1;
            s++;
         end while (!out_ready);
      end
      @(negedge clk);
      in_valid  = 0;
      out_ready = 0;
      check("post_in_ready", 32'(in_ready), 1);
      check("post_out_valid", 32'(out_valid), 0);
      check("post_cnt", 32'(fill_cnt), 0);
   endtask
   initial begin
      #2;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_fill_cnt", 32'(fill_cnt), 0);
      #10 rst_n = 1;
      run_frame(64'h0807060504030201, 0, 0);
      run_frame(64'h000110204080F0FF, 0, 0);
      run_frame(64'h0005FF0003050305, 0, 0);
      run_frame({$urandom, $urandom}, 0, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 0;
      check("mid_cnt", 32'(fill_cnt), 4);
      #2 rst_n = 0;
      #1;
      check("mid_rst_cnt", 32'(fill_cnt), 0);
      check("mid_rst_in_ready", 32'(in_ready), 1);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      #1 rst_n = 1;
      run_frame(64'h0203040506070809, 0, 0);
      run_frame({$urandom, $urandom}, 1, 0);
      for (int r = 0; r < 6; r++) run_frame({$urandom, $urandom}, 2, 2);
      run_frame({$urandom & 32'h03030303, $urandom & 32'h03030303}, 2, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
